multicycle_data_path: RTL and testbench
=======================================

Name: multicycle_data_path

Overview:
- Parametrised multi-cycle successor to the single-cycle RV64-subset datapath.
- Contains the FSM, PC, 32-entry register file, ALU and immediate generation in one block.
- Instruction and data memories are external and reached through req/ack handshakes, so wait-state memories are tolerated.
- Sits at the core top level, between the memory wrappers and the future pipeline work.

Parameters:
XLEN, 64, datapath/register width (32 or 64)
PC_W, 8, instruction word-address width; PC counts words
DMEM_AW, 8, data memory address width; address = ALU result[DMEM_AW-1:0]

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
imem_req_o  out  1  instruction fetch request
imem_addr_o  out  PC_W  fetch word address (= PC)
imem_ack_i  in  1  fetch complete; imem_rdata_i valid this cycle
imem_rdata_i  in  32  instruction word
dmem_req_o  out  1  data access request
dmem_we_o  out  1  1 = store, 0 = load
dmem_addr_o  out  DMEM_AW  data address
dmem_wdata_o  out  XLEN  store data (rs2)
dmem_ack_i  in  1  access complete; dmem_rdata_i valid this cycle for loads
dmem_rdata_i  in  XLEN  load data
retire_o  out  1  one-cycle pulse when an instruction completes
illegal_o  out  1  sticky: unsupported opcode encountered, core halted
pc_o  out  PC_W  current PC (debug)

Behaviour:
- Reset (async assert, sync release):
  - PC=0, state=FETCH.
  - All 31 registers cleared to 0.
  - All outputs 0, except imem_req_o, which rises in the first cycle after release.
- Reset mid-transaction aborts the access immediately; the memory must drop any pending ack.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH:
  - imem_req_o=1 and imem_addr_o=PC, held stable until imem_ack_i.
  - On ack: latch IR, go to DECODE.
  - Ack in the same cycle as req is legal (zero wait). Ack while req=0 is ignored.
- DECODE:
  - Read rs1=IR[19:15], rs2=IR[24:20] into operand registers A/B.
  - Form the immediate by type:
    - I (ld, addi): IR[31:20]
    - S (sd): {IR[31:25], IR[11:7]}
    - B (beq): {IR[31], IR[7], IR[30:25], IR[11:8], 0}
  - Immediates are sign-extended to XLEN.
  - Unknown opcode -> HALT.
- EXECUTE:
  - R-type (0110011) ops by funct3/funct7: add, sub (funct7=0100000), and, or, xor, sll, srl, sra, slt (signed).
    - Shift amount = B[log2(XLEN)-1:0].
    - Undefined funct combos -> HALT.
  - addi (0010011, funct3=000), ld (0000011), sd (0100011): ALU = A + imm.
  - beq (1100011, funct3=000): if A==B, PC <= PC + imm[PC_W+1:2], else PC+1. Retire, then FETCH.
  - Other opcodes/branch funct3 values -> HALT.
  - R/addi -> WB; ld/sd -> MEM.
- MEM:
  - dmem_req_o=1; address = ALU[DMEM_AW-1:0]; dmem_wdata_o = B; dmem_we_o = (sd). All held until dmem_ack_i.
  - ld: latch rdata, go to WB.
  - sd: PC+1, retire, go to FETCH.
- WB:
  - Write rd=IR[11:7] with ALU result or load data.
  - Writes to x0 are discarded; x0 always reads 0.
  - PC+1, retire, go to FETCH.
- PC wraps modulo 2^PC_W; branch targets wrap the same way.
- Latency (zero-wait memories):
  - beq: 3 cycles
  - R-type/addi: 4 cycles
  - sd: 4 cycles
  - ld: 5 cycles
- retire_o is asserted in the final cycle of each instruction.
- HALT:
  - illegal_o=1, no requests issued, PC frozen at the offending instruction.
  - Exited only by reset.
- All ALU arithmetic wraps modulo 2^XLEN. No exceptions on overflow.

Optional Feature:
- Macro MCDP_PERF_CNT_EN.
- Defined:
  - Adds output cycle_cnt_o [XLEN], which counts every clock after reset release except in HALT.
  - Adds output instret_o [XLEN], which increments on each retire_o.
  - Both are cleared by reset and wrap modulo 2^XLEN.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package mcdp_pkg holds:
  - state enum
  - opcode constants (OP_R, OP_IMM, OP_LD, OP_ST, OP_BR)
  - funct3/funct7 constants
  - ALU-op enum
- One sub-module, mcdp_alu: combinational, XLEN-parametrised, ALU-op enum in, result out.
- Register file and FSM stay in the top.

Test Plan:
1. Reset then addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2 -> x3=2; retire_o pulses at cycles 4, 8, 12; pc_o=3.
2. sub/sra/slt: x1=-16, x2=2 -> sra gives -4, slt x4,x1,x2 gives 1, sub x5,x2,x1 gives 18.
3. sd x3,8(x0) then ld x6,8(x0), with dmem_ack_i delayed 3 cycles -> dmem_addr_o=8 and dmem_we_o=1 then 0; x6=2; addr/wdata held stable while waiting.
4. beq x1,x1,-8 at PC=4 -> next imem_addr_o=2; beq not taken -> 5; beq at PC=255 with +4 -> wraps to 0.
5. Opcode 1111111 -> illegal_o=1, imem_req_o stays 0 for 20 cycles, pc_o frozen; deassert rst_ni -> illegal_o=0, PC=0.
6. addi x0,x0,7 then add x1,x0,x0 -> x1=0. With MCDP_PERF_CNT_EN: instret_o=2 and cycle_cnt_o=8 after both retire.

Source files
------------

// File: rtl/mcdp_pkg.sv
// rtl/mcdp_pkg.sv - shared types and constants for multicycle_data_path
// Purpose : FSM state enum, RV64-subset opcode/funct constants and ALU-op enum
//           used by the datapath top and its ALU.
// Ports   : none (package).
package mcdp_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_ADDI    = 3'b000;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_SLT
   } alu_op_t;

endpackage

// File: rtl/multicycle_data_path_if.sv
// rtl/multicycle_data_path_if.sv - instruction/data memory req/ack bundle
// Purpose : groups the fetch and data-access handshakes of multicycle_data_path.
// Ports   : master = core side (drives req/addr/we/wdata, takes ack/rdata),
//           slave  = memory side (the reverse).
interface multicycle_data_path_if #(
   parameter int XLEN    = 64,
   parameter int PC_W    = 8,
   parameter int DMEM_AW = 8
);
   logic               imem_req_o;
   logic [PC_W-1:0]    imem_addr_o;
   logic               imem_ack_i;
   logic [31:0]        imem_rdata_i;
   logic               dmem_req_o;
   logic               dmem_we_o;
   logic [DMEM_AW-1:0] dmem_addr_o;
   logic [XLEN-1:0]    dmem_wdata_o;
   logic               dmem_ack_i;
   logic [XLEN-1:0]    dmem_rdata_i;

   modport master (
      output imem_req_o, imem_addr_o, input imem_ack_i, imem_rdata_i,
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      input  dmem_ack_i, dmem_rdata_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, output imem_ack_i, imem_rdata_i,
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      output dmem_ack_i, dmem_rdata_i
   );
endinterface

// File: rtl/mcdp_alu.sv
// rtl/mcdp_alu.sv - combinational XLEN-wide ALU for multicycle_data_path
// Purpose : add/sub/and/or/xor/sll/srl/sra/slt, all wrapping modulo 2^XLEN.
// Ports   : a_i, b_i operands; op_i ALU-op enum; y_o result.
module mcdp_alu
   import mcdp_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  alu_op_t         op_i,
   output logic [XLEN-1:0] y_o
);
   localparam int SH_W = $clog2(XLEN);

   logic [SH_W-1:0] shamt;
   assign shamt = b_i[SH_W-1:0];

   always_comb begin
      y_o = a_i + b_i;
      case (op_i)
         ALU_ADD: y_o = a_i + b_i;
         ALU_SUB: y_o = a_i - b_i;
         ALU_AND: y_o = a_i & b_i;
         ALU_OR:  y_o = a_i | b_i;
         ALU_XOR: y_o = a_i ^ b_i;
         ALU_SLL: y_o = a_i << shamt;
         ALU_SRL: y_o = a_i >> shamt;
         ALU_SRA: y_o = $signed(a_i) >>> shamt;
         ALU_SLT: y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         default: y_o = a_i + b_i;
      endcase
   end
endmodule

// File: rtl/multicycle_data_path.sv
// rtl/multicycle_data_path.sv - multi-cycle RV64-subset datapath (FSM, PC, regfile, ALU, immgen)
// Purpose : FETCH/DECODE/EXECUTE/MEM/WB/HALT core talking to external instruction and
//           data memories over req/ack handshakes (wait states tolerated).
// Ports   : clk_i, rst_ni (async active-low); mem (master modport: imem/dmem handshakes);
//           retire_o (pulse in final cycle of each instruction); illegal_o (sticky halt);
//           pc_o (current word PC).
// Option  : MCDP_PERF_CNT_EN adds cycle_cnt_o and instret_o counters.
module multicycle_data_path
   import mcdp_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int PC_W    = 8,
   parameter int DMEM_AW = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   multicycle_data_path_if.master mem,
   output logic                  retire_o,
   output logic                  illegal_o,
   output logic [PC_W-1:0]       pc_o
`ifdef MCDP_PERF_CNT_EN
   ,
   output logic [XLEN-1:0]       cycle_cnt_o,
   output logic [XLEN-1:0]       instret_o
`endif
);
   state_t             state;
   logic [PC_W-1:0]    pc;
   logic [31:0]        ir;
   logic [XLEN-1:0]    a_q, b_q, imm_q, alu_q;
   logic [XLEN-1:0]    rf [32];
   logic               imem_req_q, dmem_req_q, dmem_we_q, illegal_q;
   logic [DMEM_AW-1:0] dmem_addr_q;
   logic [XLEN-1:0]    dmem_wdata_q;

   logic [6:0] opcode, f7;
   logic [2:0] f3;
   logic [4:0] rd;
   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign f3     = ir[14:12];
   assign f7     = ir[31:25];

   // rf[0] is reset and never written, so indexing it yields the hard-wired zero.
   logic [XLEN-1:0] rs1_val, rs2_val;
   assign rs1_val = rf[ir[19:15]];
   assign rs2_val = rf[ir[24:20]];

   logic            op_known;
   logic [XLEN-1:0] imm_dec;
   always_comb begin
      op_known = (opcode == OP_R) || (opcode == OP_IMM) || (opcode == OP_LD) ||
                 (opcode == OP_ST) || (opcode == OP_BR);
      case (opcode)
         OP_ST:   imm_dec = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
         OP_BR:   imm_dec = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         default: imm_dec = {{(XLEN-12){ir[31]}}, ir[31:20]};
      endcase
   end

   // ALU-op selection; exec_ok clears for funct combinations the core does not implement.
   alu_op_t alu_op;
   logic    exec_ok, use_imm, f7_base, f7_alt;
   assign f7_base = (f7 == F7_BASE);
   assign f7_alt  = (f7 == F7_ALT);
   always_comb begin
      alu_op  = ALU_ADD;
      exec_ok = 1'b1;
      use_imm = 1'b1;
      case (opcode)
         OP_R: begin
            use_imm = 1'b0;
            exec_ok = f7_base;
            case (f3)
               F3_ADD_SUB: begin alu_op = f7_alt ? ALU_SUB : ALU_ADD; exec_ok = f7_base | f7_alt; end
               F3_SRL_SRA: begin alu_op = f7_alt ? ALU_SRA : ALU_SRL; exec_ok = f7_base | f7_alt; end
               F3_SLL:     alu_op = ALU_SLL;
               F3_SLT:     alu_op = ALU_SLT;
               F3_XOR:     alu_op = ALU_XOR;
               F3_OR:      alu_op = ALU_OR;
               F3_AND:     alu_op = ALU_AND;
               default:    exec_ok = 1'b0;
            endcase
         end
         OP_IMM:       exec_ok = (f3 == F3_ADDI);
         OP_LD, OP_ST: exec_ok = 1'b1;
         OP_BR:        exec_ok = (f3 == F3_BEQ);
         default:      exec_ok = 1'b0;
      endcase
   end

   logic [XLEN-1:0] alu_res;
   mcdp_alu #(.XLEN(XLEN)) u_alu (
      .a_i  (a_q),
      .b_i  (use_imm ? imm_q : b_q),
      .op_i (alu_op),
      .y_o  (alu_res)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= S_FETCH;
         pc           <= '0;
         ir           <= '0;
         a_q          <= '0;
         b_q          <= '0;
         imm_q        <= '0;
         alu_q        <= '0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         illegal_q    <= 1'b0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               // req is only raised here after reset; later it is set on entry to FETCH.
               if (imem_req_q && mem.imem_ack_i) begin
                  ir         <= mem.imem_rdata_i;
                  imem_req_q <= 1'b0;
                  state      <= S_DECODE;
               end else begin
                  imem_req_q <= 1'b1;
               end
            end
            S_DECODE: begin
               a_q   <= rs1_val;
               b_q   <= rs2_val;
               imm_q <= imm_dec;
               if (op_known) state <= S_EXECUTE;
               else begin
                  state     <= S_HALT;
                  illegal_q <= 1'b1;
               end
            end
            S_EXECUTE: begin
               if (!exec_ok) begin
                  state     <= S_HALT;
                  illegal_q <= 1'b1;
               end else if (opcode == OP_BR) begin
                  pc         <= (a_q == b_q) ? pc + imm_q[PC_W+1:2] : pc + PC_W'(1);
                  imem_req_q <= 1'b1;
                  state      <= S_FETCH;
               end else if (opcode == OP_LD || opcode == OP_ST) begin
                  dmem_req_q   <= 1'b1;
                  dmem_we_q    <= (opcode == OP_ST);
                  dmem_addr_q  <= alu_res[DMEM_AW-1:0];
                  dmem_wdata_q <= b_q;
                  state        <= S_MEM;
               end else begin
                  alu_q <= alu_res;
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (mem.dmem_ack_i) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  if (dmem_we_q) begin
                     pc         <= pc + PC_W'(1);
                     imem_req_q <= 1'b1;
                     state      <= S_FETCH;
                  end else begin
                     alu_q <= mem.dmem_rdata_i;
                     state <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (rd != 5'd0) rf[rd] <= alu_q;
               pc         <= pc + PC_W'(1);
               imem_req_q <= 1'b1;
               state      <= S_FETCH;
            end
            S_HALT: ;
            default: begin
               state     <= S_HALT;
               illegal_q <= 1'b1;
            end
         endcase
      end
   end

   assign mem.imem_req_o   = imem_req_q;
   assign mem.imem_addr_o  = pc;
   assign mem.dmem_req_o   = dmem_req_q;
   assign mem.dmem_we_o    = dmem_we_q;
   assign mem.dmem_addr_o  = dmem_addr_q;
   assign mem.dmem_wdata_o = dmem_wdata_q;
   assign illegal_o        = illegal_q;
   assign pc_o             = pc;

   // Store completion depends on the ack arriving, so retire is decoded from the live state.
   assign retire_o = (state == S_WB) ||
                     (state == S_EXECUTE && opcode == OP_BR && exec_ok) ||
                     (state == S_MEM && dmem_req_q && dmem_we_q && mem.dmem_ack_i);

`ifdef MCDP_PERF_CNT_EN
   logic [XLEN-1:0] cycle_q, instret_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (state != S_HALT) cycle_q <= cycle_q + XLEN'(1);
         if (retire_o)        instret_q <= instret_q + XLEN'(1);
      end
   end
   assign cycle_cnt_o = cycle_q;
   assign instret_o   = instret_q;
`endif
endmodule

// File: tb/tb_multicycle_data_path.sv
// tb/tb_multicycle_data_path.sv - directed self-checking bench for multicycle_data_path
module tb_multicycle_data_path;
   localparam int XLEN = 64, PC_W = 8, DMEM_AW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multicycle_data_path_if #(.XLEN(XLEN), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) bus ();
   logic            retire, illegal;
   logic [PC_W-1:0] pc;
`ifdef MCDP_PERF_CNT_EN
   logic [XLEN-1:0] cycle_cnt, instret;
`endif

   multicycle_data_path #(.XLEN(XLEN), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .mem       (bus),
      .retire_o  (retire),
      .illegal_o (illegal),
      .pc_o      (pc)
`ifdef MCDP_PERF_CNT_EN
      ,
      .cycle_cnt_o (cycle_cnt),
      .instret_o   (instret)
`endif
   );

   logic [31:0] imem [256];
   logic [63:0] dmem [256];
   int          dmem_wait = 0;
   int          wait_cnt;

   assign bus.imem_ack_i   = bus.imem_req_o;
   assign bus.imem_rdata_i = imem[bus.imem_addr_o];
   assign bus.dmem_ack_i   = bus.dmem_req_o && (wait_cnt >= dmem_wait);
   assign bus.dmem_rdata_i = dmem[bus.dmem_addr_o];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_cnt <= 0;
      else if (bus.dmem_req_o && !bus.dmem_ack_i) wait_cnt <= wait_cnt + 1;
      else begin
         wait_cnt <= 0;
         if (bus.dmem_ack_i && bus.dmem_we_o) dmem[bus.dmem_addr_o] <= bus.dmem_wdata_o;
      end
   end

   int n_checks = 0, n_pass = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] ld(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b011, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] sd(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_fetch(input logic [7:0] exp_addr, input int exp_gap, input string tag);
      int t = 0;
      while (!bus.imem_req_o && t < 40) begin tick(); t++; end
      check({tag, " req"}, bus.imem_req_o, 1);
      check({tag, " addr"}, bus.imem_addr_o, exp_addr);
      check({tag, " gap"}, t, exp_gap);
      tick();
   endtask

   task automatic wait_mem(input logic exp_we, input logic [7:0] exp_addr, input logic [63:0] exp_wdata,
                           input string tag);
      int t = 0;
      while (!bus.dmem_req_o && t < 60) begin tick(); t++; end
      check({tag, " req"}, bus.dmem_req_o, 1);
      check({tag, " we"}, bus.dmem_we_o, exp_we);
      check({tag, " addr"}, bus.dmem_addr_o, exp_addr);
      check({tag, " wdata"}, bus.dmem_wdata_o, exp_wdata);
      t = 0;
      while (!bus.dmem_ack_i && t < 10) begin
         tick();
         t++;
         check({tag, " addr held"}, bus.dmem_addr_o, exp_addr);
         check({tag, " wdata held"}, bus.dmem_wdata_o, exp_wdata);
      end
      tick();
   endtask

   initial begin
      logic any_req, all_ill, pc_moved;

      // Phase 1: arithmetic, retire timing, stores/loads with wait states
      clear_imem();
      imem[0]  = addi(5'd1, 5'd0, 12'd5);
      imem[1]  = addi(5'd2, 5'd0, 12'hFFD);                 // -3
      imem[2]  = r_ins(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);    // add x3 = 2
      imem[3]  = sd(5'd3, 5'd0, 12'd8);
      imem[4]  = ld(5'd6, 5'd0, 12'd8);
      imem[5]  = sd(5'd6, 5'd0, 12'd16);
      imem[6]  = addi(5'd1, 5'd0, 12'hFF0);                 // -16
      imem[7]  = addi(5'd2, 5'd0, 12'd2);
      imem[8]  = r_ins(7'h20, 5'd2, 5'd1, 3'b101, 5'd3);    // sra  -> -4
      imem[9]  = r_ins(7'h00, 5'd2, 5'd1, 3'b010, 5'd4);    // slt  -> 1
      imem[10] = r_ins(7'h20, 5'd1, 5'd2, 3'b000, 5'd5);    // sub x2-x1 -> 18
      imem[11] = r_ins(7'h00, 5'd2, 5'd1, 3'b100, 5'd7);    // xor  -> -14
      imem[12] = r_ins(7'h00, 5'd2, 5'd2, 3'b001, 5'd8);    // sll  -> 8
      imem[13] = r_ins(7'h00, 5'd2, 5'd1, 3'b101, 5'd9);    // srl
      imem[14] = r_ins(7'h00, 5'd2, 5'd1, 3'b110, 5'd10);   // or   -> -14
      imem[15] = r_ins(7'h00, 5'd5, 5'd1, 3'b111, 5'd11);   // and -16 & 18 -> 16
      imem[16] = sd(5'd3, 5'd0, 12'd0);
      imem[17] = sd(5'd4, 5'd0, 12'd0);
      imem[18] = sd(5'd5, 5'd0, 12'd0);
      imem[19] = sd(5'd7, 5'd0, 12'd0);
      imem[20] = sd(5'd8, 5'd0, 12'd0);
      imem[21] = sd(5'd9, 5'd0, 12'd0);
      imem[22] = sd(5'd10, 5'd0, 12'd0);
      imem[23] = sd(5'd11, 5'd0, 12'd0);

      rst_n = 1'b0;
      repeat (2) tick();
      check("rst imem_req", bus.imem_req_o, 0);
      check("rst dmem_req", bus.dmem_req_o, 0);
      check("rst retire", retire, 0);
      check("rst illegal", illegal, 0);
      check("rst pc", pc, 0);
      tick();
      rst_n = 1'b1;
      check("cycle0 imem_req", bus.imem_req_o, 0);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) check("cycle1 imem_req", bus.imem_req_o, 1);
         check($sformatf("retire cyc%0d", k), retire, (k % 4) == 0);
      end
      tick();
      check("pc after 3", pc, 3);

      dmem_wait = 3;
      wait_mem(1'b1, 8'd8, 64'd2, "sd x3");
      wait_mem(1'b0, 8'd8, 64'd0, "ld x6");
      dmem_wait = 0;
      wait_mem(1'b1, 8'd16, 64'd2, "sd x6");
      wait_mem(1'b1, 8'd0, 64'hFFFF_FFFF_FFFF_FFFC, "sra");
      wait_mem(1'b1, 8'd0, 64'd1, "slt");
      wait_mem(1'b1, 8'd0, 64'd18, "sub");
      wait_mem(1'b1, 8'd0, 64'hFFFF_FFFF_FFFF_FFF2, "xor");
      wait_mem(1'b1, 8'd0, 64'd8, "sll");
      wait_mem(1'b1, 8'd0, 64'h3FFF_FFFF_FFFF_FFFC, "srl");
      wait_mem(1'b1, 8'd0, 64'hFFFF_FFFF_FFFF_FFF2, "or");
      wait_mem(1'b1, 8'd0, 64'd16, "and");

      // Phase 2: branches, latency and PC wrap
      clear_imem();
      imem[0]   = addi(5'd1, 5'd0, 12'd1);
      imem[1]   = beq(5'd0, 5'd0, 13'd12);       // -> 4
      imem[2]   = beq(5'd1, 5'd2, 13'd400);      // 1 != 0 -> 3
      imem[3]   = beq(5'd0, 5'd0, 13'd1008);     // -> 255
      imem[4]   = beq(5'd1, 5'd1, 13'h1FF8);     // -8 -> 2
      imem[255] = beq(5'd0, 5'd0, 13'd4);        // wraps -> 0
      apply_reset();
      wait_fetch(8'd0, 1, "br f0");
      wait_fetch(8'd1, 3, "br f1");
      wait_fetch(8'd4, 2, "br taken fwd");
      wait_fetch(8'd2, 2, "br taken back");
      wait_fetch(8'd3, 2, "br not taken");
      wait_fetch(8'd255, 2, "br far");
      wait_fetch(8'd0, 2, "br wrap");

      // Phase 3: unknown opcode halts
      clear_imem();
      imem[0] = addi(5'd1, 5'd0, 12'd1);
      imem[1] = 32'h0000_007F;
      apply_reset();
      wait_fetch(8'd0, 1, "ill f0");
      wait_fetch(8'd1, 3, "ill f1");
      tick();
      any_req = 1'b0; all_ill = 1'b1; pc_moved = 1'b0;
      for (int k = 0; k < 20; k++) begin
         any_req  = any_req | bus.imem_req_o | bus.dmem_req_o | retire;
         all_ill  = all_ill & illegal;
         pc_moved = pc_moved | (pc != 8'd1);
         tick();
      end
      check("halt no req", any_req, 0);
      check("halt illegal", all_ill, 1);
      check("halt pc frozen", pc_moved, 0);
      rst_n = 1'b0;
      #1;
      check("async rst illegal", illegal, 0);
      check("async rst pc", pc, 0);

      // Phase 3b: undefined R-type funct (sltu) halts in EXECUTE
      clear_imem();
      imem[0] = r_ins(7'h00, 5'd1, 5'd1, 3'b011, 5'd2);
      apply_reset();
      wait_fetch(8'd0, 1, "funct f0");
      repeat (5) tick();
      check("funct illegal", illegal, 1);
      check("funct pc", pc, 0);
      check("funct no req", bus.imem_req_o, 0);

      // Phase 4: x0 writes are discarded
      clear_imem();
      imem[0] = addi(5'd0, 5'd0, 12'd7);
      imem[1] = r_ins(7'h00, 5'd0, 5'd0, 3'b000, 5'd1);
      imem[2] = sd(5'd1, 5'd0, 12'd0);
      apply_reset();
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("x0 retire cyc%0d", k), retire, (k == 4) || (k == 8));
`ifdef MCDP_PERF_CNT_EN
         if (k == 8) check("cycle_cnt", cycle_cnt, 8);
`endif
      end
      tick();
`ifdef MCDP_PERF_CNT_EN
      check("instret", instret, 2);
`endif
      wait_mem(1'b1, 8'd0, 64'd0, "x0 discard");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
